moore_seq_detector: RTL and testbench
=====================================

// Module: moore_seq_detector
// PURPOSE
//  Parametrised Moore-style serial pattern detector. It generalises the fixed
//  "101" detector: pattern and length are runtime-programmable up to PAT_W bits,
//  overlap is selectable, input is qualified by a valid strobe, and a saturating
//  match counter is provided. It sits on serial bit streams ahead of the
//  framing and alarm logic.
// PARAMETERS
//  PAT_W   8   max pattern length in bits (>=2)
//  CNT_W   8   width of the saturating match counter
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              synchronous, active-low reset (0 = reset)
//  cfg_load   in   1              pulse: capture cfg_pat/cfg_len/cfg_ovl, flush history
//  cfg_pat    in   PAT_W          pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
//  cfg_len    in   $clog2(PAT_W+1) pattern length in bits
//  cfg_ovl    in   1              1 = overlapping matches allowed, 0 = non-overlapping
//  x_valid    in   1              qualifies x for this cycle
//  x          in   1              serial data bit
//  cnt_clr    in   1              synchronous clear of match_cnt
//  z          out  1              Moore match flag, registered
//  match_cnt  out  CNT_W          saturating count of detected matches
// BEHAVIOUR
//  Reset (reset==0 at clk edge): pattern=0, len=PAT_W, ovl=1, history=0,
//   fill=0, z=0, match_cnt=0. Reset overrides all other inputs, including mid-stream.
//  Config: on cfg_load, the active pattern/len/ovl registers are loaded and
//   history/fill are cleared the same edge. z=0 on the following cycle.
//   cfg_len==0 or cfg_len>PAT_W is clamped to PAT_W. cfg_load takes priority
//   over x_valid in the same cycle, and that bit is discarded.
//  State: history shift reg hist[PAT_W-1:0] (newest bit in [0]) plus fill
//   counter 0..len (saturates at len). Moore states are IDLE/FILLING (fill<len),
//   ARMED (fill==len, no match) and MATCH (registered match flag set).
//  Per accepted bit (x_valid=1, no cfg_load): hist_n={hist[PAT_W-2:0],x};
//   fill_n=min(fill+1,len). A match occurs when fill_n==len and
//   hist_n[len-1:0]==pat[len-1:0].
//  z: set on the edge that accepts the completing bit, so it is high the cycle
//   after that bit is presented. It is high for exactly one cycle per match and
//   is cleared on the next edge regardless of x_valid. Latency is 1 clk from the
//   last bit.
//  Overlap: ovl=1 keeps the history, so the suffix of a match may start the next
//   match. ovl=0 forces fill to 0 on a match, so the next match needs len fresh bits.
//  x_valid=0: hist and fill hold; z clears (a MATCH state lasts one cycle only).
//  match_cnt: +1 per match, saturates at 2^CNT_W-1 and does not wrap. If cnt_clr
//   and a match coincide, cnt_clr wins and match_cnt becomes 0.
//  Bits shorter than len since reset/cfg_load/non-overlap match never produce z,
//   even if the partial history equals the pattern's low bits.
// TESTING
//  1. pat=101,len=3,ovl=1; bits 1,0,1,0,1 -> z high after bit3 and bit5, match_cnt=2.
//  2. Same stream with ovl=0 -> z high after bit3 only, match_cnt=1.
//  3. pat=101,len=3; bits 1,0,(x_valid=0 x2),1 -> z high one cycle after last bit;
//     z stays 0 during the gap.
//  4. PAT_W=8,pat=8'hA5,len=8; stream 0xA5 MSB-first preceded by 7 zeros
//     -> single z pulse; cfg_len=0 behaves as len=8.
//  5. CNT_W=2, pattern 11, len=2, ovl=1, 6 ones -> count saturates at 3;
//     cnt_clr together with a match -> match_cnt=0.
//  6. reset=0 mid-pattern (after bits 1,0) then 1 -> no z; cfg_load mid-stream
//     flushes history, so a pattern straddling the load gives no match.

Source files
------------

// File: rtl/moore_seq_detector.sv
// Programmable Moore serial pattern detector: matches the last len bits of a qualified stream against pat.
// z is registered, so it rises one clk after the completing bit; there is no backpressure and every valid bit is taken.
module moore_seq_detector #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pat,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_ovl,
  input  logic                       x_valid,
  input  logic                       x,
  input  logic                       cnt_clr,
  output logic                       z,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int LEN_W = $clog2(PAT_W+1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  typedef enum logic [1:0] {IDLE, FILLING, ARMED, MATCH} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] hist_n;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill_n;
  logic             hit;

  function automatic state_t fill_state(input logic [LEN_W-1:0] f, input logic [LEN_W-1:0] l);
    if (f == '0)     return IDLE;
    else if (f == l) return ARMED;
    else             return FILLING;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= LEN_MAX;
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    len_mask = '0;

    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    hist_n = {hist_q[PAT_W-2:0], x};
    fill_n = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
    // Partial history never matches: the fill count must reach len first.
    hit    = x_valid && !cfg_load && (fill_n == len_q) &&
             (((hist_n ^ pat_q) & len_mask) == '0);

    if (cfg_load) begin
      pat_d   = cfg_pat;
      len_d   = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      ovl_d   = cfg_ovl;
      hist_d  = '0;
      fill_d  = '0;
      state_d = IDLE;
    end else if (x_valid) begin
      hist_d  = hist_n;
      fill_d  = (hit && !ovl_q) ? '0 : fill_n;
      state_d = hit ? MATCH : fill_state(fill_n, len_q);
    end else begin
      state_d = fill_state(fill_q, len_q);
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign z         = (state_q == MATCH);
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed vector bench for moore_seq_detector: a main instance (CNT_W=8) and a
// narrow-counter instance (CNT_W=2) share all inputs so saturation is visible.
module tb_moore_seq_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_ovl = 1'b0;
  logic       x_valid = 1'b0;
  logic       x = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       z, z2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  moore_seq_detector #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .x_valid(x_valid), .x(x),
    .cnt_clr(cnt_clr), .z(z), .match_cnt(match_cnt)
  );

  moore_seq_detector #(.PAT_W(8), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .x_valid(x_valid), .x(x),
    .cnt_clr(cnt_clr), .z(z2), .match_cnt(match_cnt2)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       vld;
    logic       xb;
    logic       clr;
    logic       exp_z;
    logic [7:0] exp_cnt;
    logic [1:0] exp_cnt2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rst_n, input logic ld,
                     input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                     input logic vld, input logic xb, input logic clr,
                     input logic ez, input logic [7:0] ec, input logic [1:0] ec2);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.ld = ld; v.pat = pat; v.len = len;
    v.ovl = ovl; v.vld = vld; v.xb = xb; v.clr = clr;
    v.exp_z = ez; v.exp_cnt = ec; v.exp_cnt2 = ec2;
    vecs.push_back(v);
  endtask

  // Shorthands: one accepted bit, one idle cycle, one config load.
  task automatic bit_(input string n, input logic b, input logic ez, input logic [7:0] ec, input logic [1:0] ec2);
    add(n, 1, 0, 8'h00, 4'd0, 0, 1, b, 0, ez, ec, ec2);
  endtask
  task automatic gap(input string n, input logic ez, input logic [7:0] ec, input logic [1:0] ec2);
    add(n, 1, 0, 8'h00, 4'd0, 0, 0, 0, 0, ez, ec, ec2);
  endtask
  task automatic load(input string n, input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic clr, input logic [7:0] ec, input logic [1:0] ec2);
    add(n, 1, 1, p, l, o, 0, 0, clr, 0, ec, ec2);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    reset = v.rst_n; cfg_load = v.ld; cfg_pat = v.pat; cfg_len = v.len;
    cfg_ovl = v.ovl; x_valid = v.vld; x = v.xb; cnt_clr = v.clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;

    add("reset", 0, 0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 0, 0);

    // Overlapping 101
    load("t1_load", 8'h05, 4'd3, 1, 0, 0, 0);
    bit_("t1_b1", 1, 0, 0, 0);
    bit_("t1_b2", 0, 0, 0, 0);
    bit_("t1_b3", 1, 1, 1, 1);
    bit_("t1_b4", 0, 0, 1, 1);
    bit_("t1_b5", 1, 1, 2, 2);

    // Non-overlapping 101
    load("t2_load", 8'h05, 4'd3, 0, 1, 0, 0);
    bit_("t2_b1", 1, 0, 0, 0);
    bit_("t2_b2", 0, 0, 0, 0);
    bit_("t2_b3", 1, 1, 1, 1);
    bit_("t2_b4", 0, 0, 1, 1);
    bit_("t2_b5", 1, 0, 1, 1);

    // Valid gap inside the pattern, and z clears on an idle cycle
    load("t3_load", 8'h05, 4'd3, 1, 1, 0, 0);
    bit_("t3_b1", 1, 0, 0, 0);
    bit_("t3_b2", 0, 0, 0, 0);
    gap("t3_gap1", 0, 0, 0);
    gap("t3_gap2", 0, 0, 0);
    bit_("t3_b3", 1, 1, 1, 1);
    gap("t3_zclr", 0, 1, 1);

    // 0xA5 with cfg_len=0 clamped to 8, preceded by 7 zeros
    load("t4_load", 8'hA5, 4'd0, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) bit_($sformatf("t4_pre%0d", i), 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--)
      bit_($sformatf("t4_pat%0d", i), a5[i], (i == 0), (i == 0) ? 8'd1 : 8'd0, (i == 0) ? 2'd1 : 2'd0);
    bit_("t4_after", 0, 0, 1, 1);

    // Pattern 11: narrow counter saturates, clear beats a coinciding match
    load("t5_load", 8'h03, 4'd2, 1, 1, 0, 0);
    bit_("t5_b1", 1, 0, 0, 0);
    bit_("t5_b2", 1, 1, 1, 1);
    bit_("t5_b3", 1, 1, 2, 2);
    bit_("t5_b4", 1, 1, 3, 3);
    bit_("t5_b5", 1, 1, 4, 3);
    bit_("t5_b6", 1, 1, 5, 3);
    add("t5_clr_hit", 1, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 0, 0);
    gap("t5_idle", 0, 0, 0);

    // Reset mid-pattern restores pattern=0, len=8
    load("t6_load", 8'h05, 4'd3, 1, 0, 0, 0);
    bit_("t6_b1", 1, 0, 0, 0);
    bit_("t6_b2", 0, 0, 0, 0);
    add("t6_reset", 0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 0, 0, 0);
    bit_("t6_b3", 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) bit_($sformatf("t6_z%0d", i), 0, 0, 0, 0);
    bit_("t6_zeros8", 0, 1, 1, 1);

    // cfg_load mid-stream flushes history and discards its own bit
    load("t7_load", 8'h05, 4'd3, 1, 1, 0, 0);
    bit_("t7_b1", 1, 0, 0, 0);
    bit_("t7_b2", 0, 0, 0, 0);
    add("t7_reload", 1, 1, 8'h05, 4'd3, 1, 1, 1, 0, 0, 0, 0);
    bit_("t7_c1", 1, 0, 0, 0);
    bit_("t7_c2", 0, 0, 0, 0);
    bit_("t7_c3", 1, 1, 1, 1);

    foreach (vecs[k]) begin
      drive(vecs[k]);
      check({vecs[k].name, ".z"}, int'(z), int'(vecs[k].exp_z));
      check({vecs[k].name, ".z2"}, int'(z2), int'(vecs[k].exp_z));
      check({vecs[k].name, ".cnt"}, int'(match_cnt), int'(vecs[k].exp_cnt));
      check({vecs[k].name, ".cnt2"}, int'(match_cnt2), int'(vecs[k].exp_cnt2));
    end

    // Long run of matches: 8-bit counter saturates at 255 and does not wrap
    begin
      vec_t v;
      v = '{name: "sat_load", rst_n: 1, ld: 1, pat: 8'h03, len: 4'd2, ovl: 1,
            vld: 0, xb: 0, clr: 1, exp_z: 0, exp_cnt: 0, exp_cnt2: 0};
      drive(v);
      v.ld = 0; v.clr = 0; v.vld = 1; v.xb = 1;
      for (int i = 0; i < 300; i++) drive(v);
      check("sat.cnt", int'(match_cnt), 255);
      check("sat.cnt2", int'(match_cnt2), 3);
      check("sat.z", int'(z), 1);
      v.vld = 0;
      drive(v);
      check("sat.hold_cnt", int'(match_cnt), 255);
      check("sat.hold_z", int'(z), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
